// File: rtl/gb_cart_bus_mapper.sv
// rtl/gb_cart_bus_mapper.sv - configurable MBC register file and sequenced cartridge bus-cycle engine
// Optional macro GB_CART_ROM0_REMAP_EN: a ROM bank write of 0 stores 1 (MBC1/MBC3 style).
module gb_cart_bus_mapper #(
  parameter int ROM_BANK_W = 6,
  parameter int RAM_BANK_W = 4,
  parameter int CLK_DIV    = 4,
  parameter int WAIT_TICKS = 1
) (
  input  logic                                           clk_sys,
  input  logic                                           reset,
  input  logic                                           enable,
  input  logic                                           ce_cpu,
  input  logic [14:0]                                    cart_addr,
  input  logic                                           cart_a15,
  input  logic                                           nCS,
  input  logic                                           cart_rd,
  input  logic                                           cart_wr,
  input  logic [7:0]                                     cart_di,
  input  logic                                           bus_start,
  input  logic [ROM_BANK_W-1:0]                          rom_mask,
  input  logic [((RAM_BANK_W > 0) ? RAM_BANK_W : 1)-1:0] ram_mask,
  output logic [7:0]                                     cart_do,
  output logic                                           bus_busy,
  output logic                                           bus_done,
  output logic [22:0]                                    mbc_addr,
  output logic [16:0]                                    cram_addr,
  output logic                                           ram_en,
  output logic                                           cam_en,
  output logic                                           pin_clk,
  output logic                                           pin_wr_n,
  output logic                                           pin_rd_n,
  output logic                                           pin_cs_n,
  output logic [15:0]                                    pin_addr,
  output logic [7:0]                                     pin_dout,
  input  logic [7:0]                                     pin_din,
  output logic                                           pin_dir
);

  localparam int RBW = (RAM_BANK_W > 0) ? RAM_BANK_W : 1;
  localparam int DW  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int WW  = (WAIT_TICKS > 1) ? $clog2(WAIT_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_CAPTURE
  } state_t;

  state_t                r_state;
  logic [WW-1:0]         r_wait;
  logic [DW-1:0]         r_div;
  logic                  r_pin_clk;
  logic                  r_pending;
  logic [14:0]           r_addr;
  logic                  r_a15;
  logic                  r_rd;
  logic                  r_wr;
  logic [7:0]            r_di;
  logic                  r_ncs;
  logic [ROM_BANK_W-1:0] r_rom_bank;
  logic [RBW-1:0]        r_ram_bank;
  logic                  r_ram_en;
  logic                  r_cam_en;
  logic [7:0]            r_cart_do;
  logic                  r_done;
  logic                  r_pin_wr_n;
  logic                  r_pin_rd_n;
  logic                  r_pin_cs_n;
  logic [15:0]           r_pin_addr;
  logic [7:0]            r_pin_dout;
  logic                  r_pin_dir;

  logic                  w_rst;
  logic [14:0]           w_req_addr;
  logic                  w_req_a15;
  logic                  w_req_wr;
  logic [7:0]            w_req_di;
  logic                  w_req_ncs;
  logic [15:0]           w_di_wide;
  logic [ROM_BANK_W-1:0] w_rom_wr;
  logic [RBW-1:0]        w_ram_wr;
  logic [ROM_BANK_W-1:0] w_rom_sel;
  logic                  w_unused;

  assign w_rst = reset | ~enable;

  // A request accepted in the same cycle as bus_start uses the live bus, otherwise the latched copy.
  assign w_req_addr = bus_start ? cart_addr : r_addr;
  assign w_req_a15  = bus_start ? cart_a15  : r_a15;
  assign w_req_wr   = bus_start ? cart_wr   : r_wr;
  assign w_req_di   = bus_start ? cart_di   : r_di;
  assign w_req_ncs  = bus_start ? nCS       : r_ncs;

  assign w_di_wide = {8'h00, r_di};
  assign w_unused  = ^w_di_wide;

`ifdef GB_CART_ROM0_REMAP_EN
  assign w_rom_wr = (w_di_wide[ROM_BANK_W-1:0] == '0) ? ROM_BANK_W'(1) : w_di_wide[ROM_BANK_W-1:0];
`else
  assign w_rom_wr = w_di_wide[ROM_BANK_W-1:0];
`endif

  assign w_ram_wr  = (RAM_BANK_W > 0) ? w_di_wide[RBW-1:0] : '0;
  assign w_rom_sel = cart_addr[14] ? r_rom_bank : '0;

  assign mbc_addr  = (23'(w_rom_sel & rom_mask) << 14) | 23'(cart_addr[13:0]);
  assign cram_addr = (17'(r_ram_bank & ram_mask) << 13) | 17'(cart_addr[12:0]);

  assign cart_do  = r_cart_do;
  assign bus_busy = (r_state != S_IDLE);
  assign bus_done = r_done;
  assign ram_en   = r_ram_en;
  assign cam_en   = r_cam_en;
  assign pin_clk  = r_pin_clk;
  assign pin_wr_n = r_pin_wr_n;
  assign pin_rd_n = r_pin_rd_n;
  assign pin_cs_n = r_pin_cs_n;
  assign pin_addr = r_pin_addr;
  assign pin_dout = r_pin_dout;
  assign pin_dir  = r_pin_dir;

  // Cartridge clock free-runs; pin_clk is registered so it reads 0 straight out of reset.
  always_ff @(posedge clk_sys) begin
    if (w_rst) begin
      r_div     <= '0;
      r_pin_clk <= 1'b0;
    end else if (ce_cpu) begin
      r_div     <= (r_div == DW'(CLK_DIV - 1)) ? '0 : r_div + DW'(1);
      r_pin_clk <= (r_div < DW'(CLK_DIV / 2));
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_rst) begin
      r_state    <= S_IDLE;
      r_wait     <= '0;
      r_pending  <= 1'b0;
      r_addr     <= '0;
      r_a15      <= 1'b0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_di       <= '0;
      r_ncs      <= 1'b1;
      r_rom_bank <= ROM_BANK_W'(1);
      r_ram_bank <= '0;
      r_ram_en   <= 1'b0;
      r_cam_en   <= 1'b0;
      r_cart_do  <= '0;
      r_done     <= 1'b0;
      r_pin_wr_n <= 1'b1;
      r_pin_rd_n <= 1'b1;
      r_pin_cs_n <= 1'b1;
      r_pin_addr <= '0;
      r_pin_dout <= '0;
      r_pin_dir  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus_start) begin
            r_addr    <= cart_addr;
            r_a15     <= cart_a15;
            r_wr      <= cart_wr;
            r_rd      <= cart_rd & ~cart_wr;
            r_di      <= cart_di;
            r_ncs     <= nCS;
            r_pending <= 1'b1;
          end
          if (ce_cpu && (bus_start || r_pending)) begin
            r_pending  <= 1'b0;
            r_state    <= S_SETUP;
            r_pin_addr <= {w_req_a15, w_req_addr};
            r_pin_cs_n <= w_req_ncs;
            r_pin_dir  <= w_req_wr;
            r_pin_dout <= w_req_di;
          end
        end
        S_SETUP: begin
          if (ce_cpu) begin
            r_state    <= S_STROBE;
            r_wait     <= '0;
            r_pin_rd_n <= ~r_rd;
            r_pin_wr_n <= ~r_wr;
          end
        end
        S_STROBE: begin
          if (ce_cpu) begin
            if (r_wait == WW'(WAIT_TICKS - 1)) begin
              r_state    <= S_CAPTURE;
              r_pin_rd_n <= 1'b1;
              r_pin_wr_n <= 1'b1;
            end else begin
              r_wait <= r_wait + WW'(1);
            end
          end
        end
        S_CAPTURE: begin
          if (ce_cpu) begin
            if (r_wr) begin
              if (!r_a15) begin
                case (r_addr[14:13])
                  2'b00: r_ram_en <= (r_di[3:0] == 4'hA);
                  2'b01: r_rom_bank <= w_rom_wr;
                  2'b10: begin
                    r_cam_en   <= r_di[4];
                    r_ram_bank <= w_ram_wr;
                  end
                  default: ;
                endcase
              end
            end else if (r_rd) begin
              r_cart_do <= pin_din;
            end
            r_state    <= S_IDLE;
            r_done     <= 1'b1;
            r_pin_cs_n <= 1'b1;
            r_pin_dir  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_cart_bus_mapper.sv
// tb/tb_gb_cart_bus_mapper.sv - randomized self-checking bench for gb_cart_bus_mapper
// Two instances: default timing (WAIT_TICKS=1) and a WAIT_TICKS=3 copy sharing the CPU side.
module tb_gb_cart_bus_mapper;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset, enable, ce_cpu, cart_a15, nCS, cart_rd, cart_wr, bus_start;
  logic [14:0] cart_addr;
  logic [7:0]  cart_di, pin_din;
  logic [5:0]  rom_mask;
  logic [3:0]  ram_mask;
  logic [7:0]  cart_do, cart_do_3, pin_dout, pin_dout_3;
  logic        bus_busy, bus_done, ram_en, cam_en, bus_busy_3, bus_done_3, ram_en_3, cam_en_3;
  logic [22:0] mbc_addr, mbc_addr_3;
  logic [16:0] cram_addr, cram_addr_3;
  logic        pin_clk, pin_wr_n, pin_rd_n, pin_cs_n, pin_dir;
  logic        pin_clk_3, pin_wr_n_3, pin_rd_n_3, pin_cs_n_3, pin_dir_3;
  logic [15:0] pin_addr, pin_addr_3;

  gb_cart_bus_mapper dut (
    .clk_sys(clk_sys), .reset(reset), .enable(enable), .ce_cpu(ce_cpu),
    .cart_addr(cart_addr), .cart_a15(cart_a15), .nCS(nCS), .cart_rd(cart_rd), .cart_wr(cart_wr),
    .cart_di(cart_di), .bus_start(bus_start), .rom_mask(rom_mask), .ram_mask(ram_mask),
    .cart_do(cart_do), .bus_busy(bus_busy), .bus_done(bus_done), .mbc_addr(mbc_addr),
    .cram_addr(cram_addr), .ram_en(ram_en), .cam_en(cam_en), .pin_clk(pin_clk),
    .pin_wr_n(pin_wr_n), .pin_rd_n(pin_rd_n), .pin_cs_n(pin_cs_n), .pin_addr(pin_addr),
    .pin_dout(pin_dout), .pin_din(pin_din), .pin_dir(pin_dir)
  );

  gb_cart_bus_mapper #(.WAIT_TICKS(3), .CLK_DIV(4)) dut3 (
    .clk_sys(clk_sys), .reset(reset), .enable(enable), .ce_cpu(ce_cpu),
    .cart_addr(cart_addr), .cart_a15(cart_a15), .nCS(nCS), .cart_rd(cart_rd), .cart_wr(cart_wr),
    .cart_di(cart_di), .bus_start(bus_start), .rom_mask(rom_mask), .ram_mask(ram_mask),
    .cart_do(cart_do_3), .bus_busy(bus_busy_3), .bus_done(bus_done_3), .mbc_addr(mbc_addr_3),
    .cram_addr(cram_addr_3), .ram_en(ram_en_3), .cam_en(cam_en_3), .pin_clk(pin_clk_3),
    .pin_wr_n(pin_wr_n_3), .pin_rd_n(pin_rd_n_3), .pin_cs_n(pin_cs_n_3), .pin_addr(pin_addr_3),
    .pin_dout(pin_dout_3), .pin_din(pin_din), .pin_dir(pin_dir_3)
  );

  int errors = 0;
  int checks = 0;

  // 0: ce every cycle, 1: random ce, 2: ce held low
  int ce_mode = 0;
  always @(negedge clk_sys) begin
    case (ce_mode)
      0:       ce_cpu = 1'b1;
      1:       ce_cpu = ($urandom_range(0, 1) == 1);
      default: ce_cpu = 1'b0;
    endcase
  end

  // Behavioural view of the mapper registers and last captured read
  int         m_rom, m_ram;
  bit         m_ram_en, m_cam_en;
  logic [7:0] m_do;

  function automatic void model_reset();
    m_rom = 1; m_ram = 0; m_ram_en = 0; m_cam_en = 0; m_do = 8'h00;
  endfunction

  function automatic void model_cycle(input logic [15:0] a, input logic rd, input logic wr,
                                      input logic [7:0] di, input logic [7:0] din);
    int sel;
    sel = (int'(a) / 8192) % 4;
    if (wr) begin
      if (int'(a) < 32768) begin
        if (sel == 0) m_ram_en = ((int'(di) % 16) == 10);
        if (sel == 1) begin
          m_rom = int'(di) % 64;
`ifdef GB_CART_ROM0_REMAP_EN
          if (m_rom == 0) m_rom = 1;
`endif
        end
        if (sel == 2) begin
          m_cam_en = ((int'(di) / 16) % 2) == 1;
          m_ram = int'(di) % 16;
        end
      end
    end else if (rd) begin
      m_do = din;
    end
  endfunction

  function automatic logic [22:0] exp_mbc(input logic [15:0] a, input int mask);
    int bank;
    bank = a[14] ? m_rom : 0;
    return 23'(((bank & mask) * 16384) + (int'(a) % 16384));
  endfunction

  function automatic logic [16:0] exp_cram(input logic [15:0] a, input int mask);
    return 17'(((m_ram & mask) * 8192) + (int'(a) % 8192));
  endfunction

  // Measurements of the most recent run_cycle
  int          lat1, lat3, stb1, stb3, nd1, nd3;
  bit          busy_bad, timed_out;
  logic [15:0] su_addr;
  logic [7:0]  su_dout;
  logic        su_cs, su_dir, su_rdn, su_wrn;

  task automatic run_cycle(input logic [15:0] a, input logic rd, input logic wr,
                           input logic [7:0] di, input logic [7:0] din, input logic ncs);
    bit acc, got_su, s1, s3;
    int post;
    @(negedge clk_sys);
    cart_addr = a[14:0]; cart_a15 = a[15]; cart_rd = rd; cart_wr = wr;
    cart_di = di; pin_din = din; nCS = ncs; bus_start = 1'b1;
    lat1 = 0; lat3 = 0; stb1 = 0; stb3 = 0; nd1 = 0; nd3 = 0;
    busy_bad = 0; acc = 0; got_su = 0; post = 0;
    s1 = !pin_rd_n || !pin_wr_n;
    s3 = !pin_rd_n_3 || !pin_wr_n_3;
    for (int c = 0; c < 300 && post < 3; c++) begin
      @(posedge clk_sys);
      if (ce_cpu) begin
        acc = 1'b1;
        if (nd1 == 0) lat1++;
        if (nd3 == 0) lat3++;
        if (s1) stb1++;
        if (s3) stb3++;
      end
      @(negedge clk_sys);
      bus_start = 1'b0;
      s1 = !pin_rd_n || !pin_wr_n;
      s3 = !pin_rd_n_3 || !pin_wr_n_3;
      if (acc && !got_su) begin
        got_su = 1'b1;
        su_addr = pin_addr; su_dout = pin_dout; su_cs = pin_cs_n;
        su_dir = pin_dir; su_rdn = pin_rd_n; su_wrn = pin_wr_n;
      end
      if (bus_done) begin
        nd1++;
        if (bus_busy) busy_bad = 1'b1;
      end else if (acc && nd1 == 0 && !bus_busy) busy_bad = 1'b1;
      else if (!acc && bus_busy) busy_bad = 1'b1;
      if (bus_done_3) nd3++;
      if (nd1 > 0 && nd3 > 0) post++;
    end
    timed_out = (post < 3);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cart_addr = 15'h4000; cart_a15 = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({cart_do, bus_busy, bus_done} !== 10'h000) begin
      errors++; $display("FAIL reset_status: got do=%h busy=%b done=%b", cart_do, bus_busy, bus_done);
    end
    checks++;
    if ({pin_clk, pin_wr_n, pin_rd_n, pin_cs_n, pin_dir} !== 5'b01110) begin
      errors++; $display("FAIL reset_ctrl_pins: got %b exp 01110", {pin_clk, pin_wr_n, pin_rd_n, pin_cs_n, pin_dir});
    end
    checks++;
    if (pin_addr !== 16'h0000 || pin_dout !== 8'h00) begin
      errors++; $display("FAIL reset_data_pins: got addr=%h dout=%h exp 0", pin_addr, pin_dout);
    end
    checks++;
    if (mbc_addr !== 23'h004000) begin
      errors++; $display("FAIL reset_rom_bank: mbc_addr=%h exp 004000", mbc_addr);
    end
    checks++;
    if (cram_addr !== 17'h00000 || ram_en !== 1'b0 || cam_en !== 1'b0) begin
      errors++; $display("FAIL reset_ram_regs: cram=%h ram_en=%b cam_en=%b exp 0", cram_addr, ram_en, cam_en);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_plan_read();
    logic [7:0] din;
    din = 8'($urandom);
    ce_mode = 0;
    rom_mask = 6'h3F;
    run_cycle(16'h4123, 1'b1, 1'b0, 8'h00, din, 1'b1);
    model_cycle(16'h4123, 1'b1, 1'b0, 8'h00, din);
    checks++;
    if (mbc_addr !== 23'h004123) begin
      errors++; $display("FAIL read_mbc_addr: got %h exp 004123", mbc_addr);
    end
    checks++;
    if (cart_do !== din) begin
      errors++; $display("FAIL read_cart_do: got %h exp %h", cart_do, din);
    end
    checks++;
    if (timed_out || lat1 - 1 != 3 || lat3 - 1 != 5) begin
      errors++; $display("FAIL read_latency: got %0d/%0d exp 3/5 timeout=%b", lat1 - 1, lat3 - 1, timed_out);
    end
    checks++;
    if (nd1 != 1 || nd3 != 1 || busy_bad) begin
      errors++; $display("FAIL read_done_pulse: got %0d/%0d busy_bad=%b exp 1/1", nd1, nd3, busy_bad);
    end
    checks++;
    if (stb1 != 1 || stb3 != 3) begin
      errors++; $display("FAIL read_strobe_ticks: got %0d/%0d exp 1/3", stb1, stb3);
    end
    checks++;
    if ({su_addr, su_cs, su_dir, su_rdn, su_wrn} !== {16'h4123, 4'b1011}) begin
      errors++; $display("FAIL read_setup_pins: got addr=%h cs=%b dir=%b rd=%b wr=%b", su_addr, su_cs, su_dir, su_rdn, su_wrn);
    end
  endtask

  task automatic test_rom_bank();
    logic [22:0] exp0;
    run_cycle(16'h2000, 1'b0, 1'b1, 8'h25, 8'h00, 1'b1);
    model_cycle(16'h2000, 1'b0, 1'b1, 8'h25, 8'h00);
    checks++;
    if (su_dir !== 1'b1 || su_dout !== 8'h25 || stb1 != 1) begin
      errors++; $display("FAIL write_pins: got dir=%b dout=%h stb=%0d exp 1 25 1", su_dir, su_dout, stb1);
    end
    rom_mask = 6'h1F;
    run_cycle(16'h7FFF, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b1);
    model_cycle(16'h7FFF, 1'b1, 1'b0, 8'h00, 8'h5A);
    checks++;
    if (mbc_addr !== 23'h017FFF || mbc_addr !== exp_mbc(16'h7FFF, 31)) begin
      errors++; $display("FAIL rom_bank_masked: got %h exp 017FFF", mbc_addr);
    end
    rom_mask = 6'h3F;
    run_cycle(16'h2000, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
    model_cycle(16'h2000, 1'b0, 1'b1, 8'h00, 8'h00);
    cart_addr = 15'h4000;
    #1;
`ifdef GB_CART_ROM0_REMAP_EN
    exp0 = 23'h004000;
`else
    exp0 = 23'h000000;
`endif
    checks++;
    if (mbc_addr !== exp0) begin
      errors++; $display("FAIL rom_bank_zero: got %h exp %h", mbc_addr, exp0);
    end
  endtask

  task automatic test_ram_regs();
    ram_mask = 4'hF;
    run_cycle(16'h4000, 1'b0, 1'b1, 8'h13, 8'h00, 1'b1);
    model_cycle(16'h4000, 1'b0, 1'b1, 8'h13, 8'h00);
    cart_addr = 15'h0000;
    #1;
    checks++;
    if (cam_en !== 1'b1 || cram_addr !== 17'h06000) begin
      errors++; $display("FAIL cam_ram_bank: got cam=%b cram=%h exp 1 06000", cam_en, cram_addr);
    end
    run_cycle(16'h0000, 1'b0, 1'b1, 8'h0A, 8'h00, 1'b1);
    model_cycle(16'h0000, 1'b0, 1'b1, 8'h0A, 8'h00);
    checks++;
    if (ram_en !== 1'b1) begin
      errors++; $display("FAIL ram_en_set: got %b exp 1", ram_en);
    end
    run_cycle(16'h0000, 1'b0, 1'b1, 8'h1B, 8'h00, 1'b1);
    model_cycle(16'h0000, 1'b0, 1'b1, 8'h1B, 8'h00);
    checks++;
    if (ram_en !== 1'b0) begin
      errors++; $display("FAIL ram_en_clear: got %b exp 0", ram_en);
    end
    run_cycle(16'hA000, 1'b0, 1'b1, 8'h0A, 8'h00, 1'b0);
    model_cycle(16'hA000, 1'b0, 1'b1, 8'h0A, 8'h00);
    checks++;
    if (ram_en !== 1'b0 || su_cs !== 1'b0 || su_addr !== 16'hA000) begin
      errors++; $display("FAIL a15_write_no_commit: got ram_en=%b cs=%b addr=%h", ram_en, su_cs, su_addr);
    end
  endtask

  task automatic test_enable();
    run_cycle(16'h2000, 1'b0, 1'b1, 8'h05, 8'h00, 1'b1);
    run_cycle(16'h0000, 1'b0, 1'b1, 8'h0A, 8'h00, 1'b1);
    enable = 1'b0;
    @(negedge clk_sys);
    enable = 1'b1;
    cart_addr = 15'h4000;
    model_reset();
    #1;
    checks++;
    if (ram_en !== 1'b0 || mbc_addr !== exp_mbc(16'h4000, 63)) begin
      errors++; $display("FAIL enable_low_reset: got ram_en=%b mbc=%h exp 0 %h", ram_en, mbc_addr, exp_mbc(16'h4000, 63));
    end
  endtask

  task automatic test_busy_ignore();
    int nd;
    ce_mode = 0;
    @(negedge clk_sys);
    cart_addr = 15'h4001; cart_a15 = 1'b0; cart_rd = 1'b1; cart_wr = 1'b0; pin_din = 8'h77; bus_start = 1'b1;
    @(negedge clk_sys);
    bus_start = 1'b0;
    @(negedge clk_sys);
    cart_addr = 15'h0000; cart_rd = 1'b0; cart_wr = 1'b1; cart_di = 8'h0A; bus_start = 1'b1;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_sys);
      bus_start = 1'b0;
      if (bus_done) nd++;
    end
    model_cycle(16'h4001, 1'b1, 1'b0, 8'h00, 8'h77);
    checks++;
    if (nd != 1 || bus_busy !== 1'b0) begin
      errors++; $display("FAIL busy_ignore_done: got %0d pulses busy=%b exp 1 0", nd, bus_busy);
    end
    checks++;
    if (ram_en !== 1'b0 || pin_addr !== 16'h4001 || cart_do !== 8'h77) begin
      errors++; $display("FAIL busy_ignore_state: ram_en=%b addr=%h do=%h exp 0 4001 77", ram_en, pin_addr, cart_do);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    bit seen;
    ce_mode = 0;
    @(negedge clk_sys);
    cart_addr = 15'h2000; cart_a15 = 1'b0; cart_rd = 1'b0; cart_wr = 1'b1; cart_di = 8'h07; nCS = 1'b0;
    bus_start = 1'b1;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk_sys);
      bus_start = 1'b0;
      if (!pin_wr_n) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL reset_mid_strobe_seen: got no strobe exp pin_wr_n=0");
    end
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    model_reset();
    checks++;
    if ({pin_wr_n, pin_rd_n, pin_cs_n, pin_dir, bus_busy, pin_wr_n_3} !== 6'b111001 || pin_addr !== 16'h0000) begin
      errors++; $display("FAIL reset_mid_pins: got %b addr=%h exp 111001 0000",
                         {pin_wr_n, pin_rd_n, pin_cs_n, pin_dir, bus_busy, pin_wr_n_3}, pin_addr);
    end
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_sys);
      if (bus_done || bus_done_3) nd++;
    end
    cart_addr = 15'h4000;
    #1;
    checks++;
    if (nd != 0 || mbc_addr !== exp_mbc(16'h4000, 63)) begin
      errors++; $display("FAIL reset_mid_no_done: got %0d pulses mbc=%h exp 0 %h", nd, mbc_addr, exp_mbc(16'h4000, 63));
    end
  endtask

  task automatic test_divider_freeze();
    bit s[16];
    bit pc;
    int n, hi, bad, nd;
    logic [15:0] pa;
    ce_mode = 1;
    n = 0;
    for (int c = 0; c < 400 && n < 16; c++) begin
      @(negedge clk_sys);
      pc = pin_clk;
      @(posedge clk_sys);
      if (ce_cpu) begin s[n] = pc; n++; end
    end
    hi = 0; bad = 0;
    for (int i = 0; i < 16; i++) if (s[i]) hi++;
    for (int i = 0; i < 14; i++) if (s[i] == s[i + 2]) bad++;
    checks++;
    if (n != 16 || hi != 8) begin
      errors++; $display("FAIL pin_clk_duty: got %0d high of %0d ticks exp 8 of 16", hi, n);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL pin_clk_period: got %0d phase errors exp 0", bad);
    end
    ce_mode = 2;
    repeat (2) @(negedge clk_sys);
    pc = pin_clk; pa = pin_addr;
    cart_addr = 15'h4055; cart_a15 = 1'b0; cart_rd = 1'b1; cart_wr = 1'b0; pin_din = 8'h3C; bus_start = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_sys);
      bus_start = 1'b0;
      if (pin_clk !== pc || bus_busy !== 1'b0 || pin_addr !== pa) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL freeze_hold: got %0d changed samples exp 0", bad);
    end
    ce_mode = 0;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_sys);
      if (bus_done) nd++;
    end
    model_cycle(16'h4055, 1'b1, 1'b0, 8'h00, 8'h3C);
    checks++;
    if (nd != 1 || cart_do !== m_do || pin_addr !== 16'h4055) begin
      errors++; $display("FAIL pending_start: got %0d pulses do=%h addr=%h exp 1 3c 4055", nd, cart_do, pin_addr);
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0]  di, din;
    logic        rd, wr, ncs;
    int          rm, am, exp_stb;
    for (int it = 0; it < 40; it++) begin
      ce_mode = $urandom_range(0, 1);
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hA000, 16'hBFFF)) : 16'($urandom_range(0, 16'h7FFF));
      rd = 1'($urandom); wr = 1'($urandom); ncs = 1'($urandom);
      di = 8'($urandom); din = 8'($urandom);
      rm = $urandom_range(0, 63); am = $urandom_range(0, 15);
      rom_mask = 6'(rm); ram_mask = 4'(am);
      run_cycle(a, rd, wr, di, din, ncs);
      model_cycle(a, rd, wr, di, din);
      exp_stb = (rd || wr) ? 1 : 0;
      checks++;
      if (timed_out || lat1 - 1 != 3 || lat3 - 1 != 5 || nd1 != 1 || nd3 != 1 || busy_bad) begin
        errors++; $display("FAIL rnd_timing[%0d]: lat=%0d/%0d done=%0d/%0d busy_bad=%b exp 3/5 1/1 0",
                           it, lat1 - 1, lat3 - 1, nd1, nd3, busy_bad);
      end
      checks++;
      if (stb1 != exp_stb || stb3 != 3 * exp_stb) begin
        errors++; $display("FAIL rnd_strobe[%0d]: got %0d/%0d exp %0d/%0d", it, stb1, stb3, exp_stb, 3 * exp_stb);
      end
      checks++;
      if ({su_addr, su_cs, su_dir, su_rdn, su_wrn} !== {a, ncs, wr, 2'b11} || su_dout !== di) begin
        errors++; $display("FAIL rnd_setup[%0d]: addr=%h cs=%b dir=%b rd=%b wr=%b dout=%h", it, su_addr, su_cs, su_dir, su_rdn, su_wrn, su_dout);
      end
      checks++;
      if (cart_do !== m_do || cart_do_3 !== m_do) begin
        errors++; $display("FAIL rnd_cart_do[%0d]: got %h/%h exp %h", it, cart_do, cart_do_3, m_do);
      end
      checks++;
      if (mbc_addr !== exp_mbc(a, rm) || cram_addr !== exp_cram(a, am)) begin
        errors++; $display("FAIL rnd_map[%0d]: got %h %h exp %h %h", it, mbc_addr, cram_addr, exp_mbc(a, rm), exp_cram(a, am));
      end
      checks++;
      if (ram_en !== m_ram_en || cam_en !== m_cam_en) begin
        errors++; $display("FAIL rnd_flags[%0d]: got ram_en=%b cam_en=%b exp %b %b", it, ram_en, cam_en, m_ram_en, m_cam_en);
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; ce_cpu = 1'b0;
    cart_addr = '0; cart_a15 = 1'b0; nCS = 1'b1; cart_rd = 1'b0; cart_wr = 1'b0;
    cart_di = '0; pin_din = '0; bus_start = 1'b0; rom_mask = 6'h3F; ram_mask = 4'hF;
    test_reset();
    test_plan_read();
    test_rom_bank();
    test_ram_regs();
    test_enable();
    test_busy_ignore();
    test_reset_mid();
    test_divider_freeze();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gb_cart_bus_mapper.md
# gb_cart_bus_mapper

Parametrised cartridge-bus mapper for the Game Boy core. It replaces the fixed single-mapper logic with a configurable MBC register file: ROM and RAM bank widths and masks are parameters. A sequenced bus-cycle engine drives a physical cartridge slot through the cart-transceiver pins with explicit setup, strobe, wait-state and capture phases. It sits between the CPU cart bus and the cart_tran_* pin banks, and returns read data and a completion handshake to the CPU side.

## Interface
Parameters:
- ROM_BANK_W, 6, ROM bank register width (1..9).
- RAM_BANK_W, 4, RAM bank register width (0..4).
- CLK_DIV, 4, ce_cpu ticks per cartridge clock period (even, ≥2).
- WAIT_TICKS, 1, ce_cpu ticks the strobe stays asserted (≥1).

Ports:
- clk_sys  in  1  system clock. One clock domain: clk_sys only.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  mapper selected; low acts as reset for all registers and the FSM.
- ce_cpu  in  1  CPU clock enable; all FSM and divider steps occur on ce_cpu.
- cart_addr  in  15  CPU address A14..A0.
- cart_a15  in  1  CPU A15.
- nCS  in  1  CPU external-RAM chip select, active low.
- cart_rd, cart_wr  in  1 each  CPU strobes, sampled with bus_start.
- cart_di  in  8  CPU write data.
- bus_start  in  1  one-cycle request to run a cart bus cycle.
- rom_mask  in  ROM_BANK_W  ROM bank mirror mask.
- ram_mask  in  max(RAM_BANK_W,1)  RAM bank mirror mask.
- cart_do  out  8  captured read data.
- bus_busy  out  1  engine not idle.
- bus_done  out  1  one-cycle completion pulse.
- mbc_addr  out  23  mapped ROM byte address.
- cram_addr  out  17  mapped cart-RAM byte address.
- ram_en, cam_en  out  1 each  RAM enable / camera register select.
- pin_clk, pin_wr_n, pin_rd_n, pin_cs_n  out  1 each  cartridge control pins.
- pin_addr  out  16  cartridge address pins.
- pin_dout  out  8, pin_din  in  8, pin_dir  out  1  data pins; pin_dir=1 drives pin_dout.

## Operation
- MBC register writes commit at CAPTURE of a write cycle with cart_a15=0, decoded on addr[14:13]:
  - 00: ram_en <= (di[3:0]==4'hA).
  - 01: rom_bank <= di[ROM_BANK_W-1:0].
  - 10: cam_en <= di[4]; ram_bank <= di[RAM_BANK_W-1:0].
  - 11: ignored.
- mbc_addr = zero-extended {(addr[14] ? rom_bank : 0) & rom_mask, addr[13:0]}. Combinational.
- cram_addr = zero-extended {ram_bank & ram_mask, addr[12:0]}.
- Divider: counter 0..CLK_DIV-1 increments per ce_cpu and wraps to 0. pin_clk is high while count < CLK_DIV/2. It free-runs independent of the FSM.
- FSM states, each advancing on ce_cpu:
  - IDLE: on a latched bus_start, capture addr, a15, rd, wr, di and nCS. Go to SETUP.
  - SETUP (1 tick): pin_addr driven; pin_cs_n = nCS_latched; strobes high; pin_dir = wr.
  - STROBE (WAIT_TICKS ticks): pin_rd_n or pin_wr_n low.
  - CAPTURE (1 tick): strobes high; a read samples pin_din into cart_do; a write commits MBC regs. Then go to IDLE and pulse bus_done.
- A bus_start arriving between ce_cpu ticks is held pending. A bus_start while bus_busy=1 is ignored and not queued.
- rd and wr both set at bus_start: treated as write, rd ignored.
- Neither set: cycle runs with both strobes high, then completes normally.

## Timing
- Reset values: rom_bank=1, ram_bank=0, ram_en=0, cam_en=0, divider=0, pin_clk=0, pin_*_n=1, pin_addr=0, pin_dout=0, pin_dir=0, cart_do=0, bus_busy=0, bus_done=0.
- Latency from accepting bus_start to bus_done: 2+WAIT_TICKS ce_cpu ticks. bus_done is high for exactly one clk_sys cycle.
- bus_busy rises the cycle after acceptance and falls together with bus_done.
- Reset or enable low mid-cycle: FSM goes to IDLE on the next edge, strobes deassert, no bus_done, MBC regs return to reset values.
- ce_cpu held low freezes the FSM and divider. Outputs hold.

## Configuration
- GB_CART_ROM0_REMAP_EN defined: a write of 0 to the ROM bank register stores 1, MBC1/MBC3 style; the mapping is applied before masking.
- GB_CART_ROM0_REMAP_EN undefined: 0 is stored as-is, giving camera-style direct bank 0 access.

## Test plan
- Reset, then read 0x4123 with rom_mask=all ones → mbc_addr=0x04123, cart_do=pin_din after 3 ticks (WAIT_TICKS=1), one bus_done pulse.
- Write 0x2000←0x25, then read 0x7FFF with rom_mask=0x1F → mbc_addr=0x17FFF (0x25&0x1F=0x05).
- Write 0x2000←0x00 → rom_bank=1 with macro defined; rom_bank=0 without it.
- Write 0x4000←0x13, RAM_BANK_W=4 → cam_en=1, ram_bank=3; 0x0000←0x0A → ram_en=1; 0x0000←0x1B → ram_en=0.
- Issue bus_start while busy → ignored, exactly one bus_done. Assert reset during STROBE → pins return to reset values next cycle, no bus_done.
- WAIT_TICKS=3, CLK_DIV=4 → strobe low for exactly 3 ce_cpu ticks; pin_clk period is 4 ticks at 50% duty.
